// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: next-PC/hazard controls in, IF/ID pipeline register and I-mem address out.
// Purely wires; no latency of its own.
// No backpressure on the bundle itself; Stall is the only hold mechanism.
interface fetch_stage_if;
    logic [31:0] nPC;
    logic        Stall;
    logic        Flush;
    logic [31:0] IMAddr;
    logic [31:0] IMData;
    logic [31:0] PC;
    logic [31:0] PCID;
    logic [31:0] InstructionID;
    logic        ValidID;
    logic        AdELID;
    logic [15:0] StallCnt;

    // The fetch stage drives the pipeline register and memory address
    modport master (
        input  nPC, Stall, Flush, IMData,
        output IMAddr, PC, PCID, InstructionID, ValidID, AdELID, StallCnt
    );

    // Hazard unit, next-PC logic and instruction memory side
    modport slave (
        output nPC, Stall, Flush, IMData,
        input  IMAddr, PC, PCID, InstructionID, ValidID, AdELID, StallCnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, fetch-address check and IF/ID pipeline register.
// Latency: instruction at PC appears on InstructionID one edge later; IMAddr is combinational on PC.
// Backpressure: Stall holds PC and IF/ID; Flush turns IF/ID into a bubble regardless of Stall.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_TOP   = 32'h0000_4FFC
) (
    input  logic clk,
    input  logic reset,
    fetch_stage_if.master bus
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pcid;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        adel_id;
    logic [15:0] stall_cnt;

    logic        fetch_err;
    logic [31:0] fetch_word;

    // Address check: misaligned or outside the instruction window fetches a nop
    always_comb begin
        fetch_err  = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);
        fetch_word = fetch_err ? 32'h0000_0000 : bus.IMData;
    end

    // FSM, PC and IF/ID register; BOOT spends one edge loading a bubble before fetching
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= PC_RESET;
            pcid      <= PC_RESET;
            instr_id  <= 32'h0000_0000;
            valid_id  <= 1'b0;
            adel_id   <= 1'b0;
            stall_cnt <= 16'h0000;
        end else begin
            case (state)
                BOOT: begin
                    instr_id <= 32'h0000_0000;
                    valid_id <= 1'b0;
                    adel_id  <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (!bus.Stall) begin
                        pc <= bus.nPC;
                    end
                    if (bus.Stall && (stall_cnt != 16'hFFFF)) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                    if (bus.Flush) begin
                        // Bubble keeps PCID so a later exception still sees a sane PC
                        instr_id <= 32'h0000_0000;
                        valid_id <= 1'b0;
                        adel_id  <= 1'b0;
                    end else if (!bus.Stall) begin
                        pcid     <= pc + 32'd4;
                        instr_id <= fetch_word;
                        valid_id <= 1'b1;
                        adel_id  <= fetch_err;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Everything except IMAddr comes straight from a register
    assign bus.IMAddr        = pc;
    assign bus.PC            = pc;
    assign bus.PCID          = pcid;
    assign bus.InstructionID = instr_id;
    assign bus.ValidID       = valid_id;
    assign bus.AdELID        = adel_id;
    assign bus.StallCnt      = stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-edge vectors through a scoreboard queue,
// then hand-written async-reset and stall-counter saturation sequences.
// Instruction memory is a combinational function of IMAddr.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0005;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.IMData = imem(bus.IMAddr);

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] pcid;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t r(input logic s, input logic f, input logic [31:0] n,
                               input logic [31:0] p, input logic [31:0] pid,
                               input logic [31:0] i, input logic v, input logic a,
                               input logic [15:0] c);
        vec_t x;
        x.stall = s; x.flush = f; x.npc = n; x.pc = p; x.pcid = pid;
        x.inst = i; x.valid = v; x.adel = a; x.cnt = c;
        return x;
    endfunction

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [18];
    vec_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] p, input logic [31:0] pid,
                           input logic [31:0] i, input logic v, input logic a,
                           input logic [15:0] c);
        chk({tag, " PC"}, bus.PC, p);
        chk({tag, " IMAddr"}, bus.IMAddr, p);
        chk({tag, " PCID"}, bus.PCID, pid);
        chk({tag, " InstructionID"}, bus.InstructionID, i);
        chk({tag, " ValidID"}, {31'd0, bus.ValidID}, {31'd0, v});
        chk({tag, " AdELID"}, {31'd0, bus.AdELID}, {31'd0, a});
        chk({tag, " StallCnt"}, {16'd0, bus.StallCnt}, {16'd0, c});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //       stall flush nPC           PC            PCID          Inst          V  A  Cnt
        tbl[0]  = r(1, 1, 32'h0000_3004, 32'h0000_3000, 32'h0000_3000, 32'h0000_0000, 0, 0, 16'd0);
        tbl[1]  = r(0, 0, 32'h0000_3004, 32'h0000_3004, 32'h0000_3004, 32'h2408_0005, 1, 0, 16'd0);
        tbl[2]  = r(0, 0, 32'h0000_3008, 32'h0000_3008, 32'h0000_3008, 32'hA5A5_3004, 1, 0, 16'd0);
        tbl[3]  = r(1, 0, 32'h0000_3010, 32'h0000_3008, 32'h0000_3008, 32'hA5A5_3004, 1, 0, 16'd1);
        tbl[4]  = r(1, 0, 32'h0000_3010, 32'h0000_3008, 32'h0000_3008, 32'hA5A5_3004, 1, 0, 16'd2);
        tbl[5]  = r(1, 0, 32'h0000_3010, 32'h0000_3008, 32'h0000_3008, 32'hA5A5_3004, 1, 0, 16'd3);
        tbl[6]  = r(0, 0, 32'h0000_3010, 32'h0000_3010, 32'h0000_300C, 32'hA5A5_3008, 1, 0, 16'd3);
        tbl[7]  = r(0, 1, 32'h0000_3008, 32'h0000_3008, 32'h0000_300C, 32'h0000_0000, 0, 0, 16'd3);
        tbl[8]  = r(1, 1, 32'h0000_3040, 32'h0000_3008, 32'h0000_300C, 32'h0000_0000, 0, 0, 16'd4);
        tbl[9]  = r(0, 0, 32'h0000_3002, 32'h0000_3002, 32'h0000_300C, 32'hA5A5_3008, 1, 0, 16'd4);
        tbl[10] = r(0, 0, 32'h0000_5000, 32'h0000_5000, 32'h0000_3006, 32'h0000_0000, 1, 1, 16'd4);
        tbl[11] = r(0, 0, 32'h0000_4FFC, 32'h0000_4FFC, 32'h0000_5004, 32'h0000_0000, 1, 1, 16'd4);
        tbl[12] = r(0, 0, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0000_5000, 32'hA5A5_4FFC, 1, 0, 16'd4);
        tbl[13] = r(0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3000, 32'h0000_0000, 1, 1, 16'd4);
        tbl[14] = r(0, 0, 32'h0000_3040, 32'h0000_3040, 32'h0000_0000, 32'h0000_0000, 1, 1, 16'd4);
        tbl[15] = r(1, 0, 32'h0000_3000, 32'h0000_3040, 32'h0000_0000, 32'h0000_0000, 1, 1, 16'd5);
        tbl[16] = r(1, 0, 32'h0000_3000, 32'h0000_3040, 32'h0000_0000, 32'h0000_0000, 1, 1, 16'd6);
        tbl[17] = r(1, 0, 32'h0000_3000, 32'h0000_3040, 32'h0000_0000, 32'h0000_0000, 1, 1, 16'd7);

        reset     = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        bus.nPC   = 32'h0000_3004;

        // Reset values must be present before the first clock edge
        #1;
        chk_all("reset", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0, 16'd0);

        step();
        reset = 1'b0;

        // Table vectors: expected record queued at drive time, popped after the edge
        for (int k = 0; k < 18; k++) begin
            vec_t e;
            bus.Stall = tbl[k].stall;
            bus.Flush = tbl[k].flush;
            bus.nPC   = tbl[k].npc;
            exp_q.push_back(tbl[k]);
            step();
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard: got empty queue required 1 entry");
            end else begin
                e = exp_q.pop_front();
                chk_all($sformatf("vec%0d", k), e.pc, e.pcid, e.inst, e.valid, e.adel, e.cnt);
            end
        end
        chk("queue drained", exp_q.size(), 32'd0);

        // Asynchronous reset mid-cycle with StallCnt=7 and PC=0x3040
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0, 16'd0);

        // Reset held across an edge with Stall/Flush active keeps reset values
        bus.Stall = 1'b1;
        bus.Flush = 1'b1;
        bus.nPC   = 32'h0000_3100;
        step();
        chk_all("reset held", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0, 16'd0);
        reset     = 1'b0;
        bus.Flush = 1'b0;

        // BOOT edge ignores Stall: counter stays at zero
        step();
        chk_all("boot stalled", 32'h3000, 32'h3000, 32'h0, 1'b0, 1'b0, 16'd0);

        // Stall counter saturation
        for (int k = 0; k < 65534; k++) step();
        chk("stallcnt FFFE", {16'd0, bus.StallCnt}, 32'h0000_FFFE);
        step();
        chk("stallcnt FFFF", {16'd0, bus.StallCnt}, 32'h0000_FFFF);
        for (int k = 0; k < 5; k++) step();
        chk("stallcnt sat", {16'd0, bus.StallCnt}, 32'h0000_FFFF);
        chk("pc held in stall", bus.PC, 32'h0000_3000);

        // Leaving the stall fetches normally and the counter stays saturated
        bus.Stall = 1'b0;
        bus.nPC   = 32'h0000_3004;
        step();
        chk_all("after sat", 32'h3004, 32'h3004, 32'h2408_0005, 1'b1, 1'b0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; all state is reset asynchronously on reset=1.
REQ-002 SHALL have ports: clk input 1 (system clock, rising edge); reset input 1 (asynchronous, active-high).
REQ-003 SHALL have ports: nPC input 32 (next PC from the next-PC logic); Stall input 1 (hazard unit, hold IF and IF/ID); Flush input 1 (clear IF/ID to bubble).
REQ-004 SHALL have ports: IMAddr output 32 (instruction-memory byte address, equals PC); IMData input 32 (combinational instruction word at IMAddr).
REQ-005 SHALL have ports: PC output 32 (current fetch PC); PCID output 32 (PC+4 of the instruction in ID); InstructionID output 32 (instruction in ID).
REQ-006 SHALL have ports: ValidID output 1 (ID holds a real instruction); AdELID output 1 (ID instruction had a fetch address error); StallCnt output 16 (stall-cycle counter).
REQ-007 SHALL define parameters: PC_RESET, default 32'h0000_3000, boot PC; IM_BASE, default 32'h0000_3000, lowest legal fetch address; IM_TOP, default 32'h0000_4FFC, highest legal fetch address.

Function
REQ-008 SHALL drive IMAddr = PC combinationally.
REQ-009 SHALL flag a fetch error FE = (PC[1:0] != 0) OR (PC < IM_BASE) OR (PC > IM_TOP), using unsigned compare.
REQ-010 SHALL substitute the fetched word with 32'h0000_0000 (nop) when FE=1; IMData is then ignored.
REQ-011 SHALL run a two-state FSM: BOOT (entered on reset) and RUN.
REQ-012 In BOOT, SHALL load IF/ID with a bubble and leave PC unchanged at the first clk edge; the FSM SHALL then go to RUN, Stall and Flush being ignored in BOOT.
REQ-013 In RUN with Stall=0, SHALL update on each edge: PC <= nPC; PCID <= PC+4 (mod 2^32); InstructionID <= fetched or substituted word; ValidID <= 1; AdELID <= FE.
REQ-014 In RUN with Stall=1 and Flush=0, SHALL hold PC, PCID, InstructionID, ValidID and AdELID unchanged.
REQ-015 In RUN with Flush=1, SHALL load IF/ID with a bubble regardless of Stall, and PC SHALL follow Stall (held if Stall=1, else nPC).
REQ-016 A bubble SHALL mean InstructionID=0, ValidID=0, AdELID=0 and PCID unchanged.
REQ-017 StallCnt SHALL increment by 1 on each RUN-state edge with Stall=1, saturate at 16'hFFFF and never wrap.
REQ-018 Latency SHALL be: the instruction at PC appears on InstructionID one edge later when not stalled; the nPC produced from PCID/InstructionID is taken by PC on the same edge.
REQ-019 PC+4 overflow SHALL wrap mod 2^32 for PCID, and the following fetch SHALL be flagged by REQ-009.
REQ-020 All outputs SHALL be glitch-free registered values except IMAddr, which is combinational on PC.

Reset
REQ-021 SHALL set, on reset=1 at any time (including mid-stall or mid-flush): PC=PC_RESET, PCID=PC_RESET, InstructionID=0, ValidID=0, AdELID=0, StallCnt=0, FSM=BOOT.
REQ-022 Outputs SHALL take reset values without waiting for a clk edge, and SHALL hold them while reset=1.

Verification
REQ-023 Boot: release reset, IMData=32'h2408_0005 at 0x3000 -> edge1: PC=0x3000, ValidID=0; edge2: InstructionID=0x24080005, PCID=0x3004, ValidID=1, PC=nPC.
REQ-024 Stall: Stall=1 for 3 edges in RUN with nPC=0x3010 -> PC, PCID, InstructionID unchanged and StallCnt=3; after Stall=0, next edge PC=0x3010.
REQ-025 Flush+Stall: Stall=1, Flush=1 at PC=0x3008 -> after edge: PC=0x3008, InstructionID=0, ValidID=0, PCID unchanged.
REQ-026 Fetch error: nPC=0x3002, then nPC=0x5000 -> InstructionID=0, AdELID=1, ValidID=1 on each following edge.
REQ-027 Async reset: assert reset mid-clock with StallCnt=7, PC=0x3040 -> immediately PC=0x3000, StallCnt=0, ValidID=0 before any clk edge.
REQ-028 Saturation: preload via 65540 stalled edges -> StallCnt=16'hFFFF and it stays there.
